// File: rtl/mvu_apb_irq_hub.sv
// ---------------------------------------------------------------------------
// mvu_apb_irq_hub
//
// APB3 fabric between the SoC APB master and NCH MVU APB slaves, with a small
// local interrupt block and a per-transfer timeout.
//
// The channel index is taken from s_paddr[CH_AW +: SELW]:
//   sel <  NCH : the transfer is forwarded to MVU port `sel`
//   sel == NCH : local IRQ registers (PENDING / MASK / RAW)
//   sel >  NCH : no target; completes at once with s_pslverr
// Only one transfer is in flight. The upstream side sees s_pready only in
// the single RESP cycle, so it is held in its access phase until then.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s_psel .. s_pwdata    upstream APB3 request
//   s_prdata, s_pready,   upstream response (registered, one-cycle pready)
//   s_pslverr
//   m_psel                one-hot downstream select
//   m_penable, m_pwrite,  shared downstream request signals
//   m_paddr, m_pwdata
//   m_prdata, m_pready,   downstream responses, channel i at slice i
//   m_pslverr
//   mvu_irq               raw MVU interrupt levels
//   irq_o                 pending & mask per hart (registered)
//   irq_any_o             OR of irq_o
// ---------------------------------------------------------------------------
module mvu_apb_irq_hub #(
    parameter int NCH     = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int CH_AW   = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_psel,
    input  logic                  s_penable,
    input  logic                  s_pwrite,
    input  logic [ADDR_W-1:0]     s_paddr,
    input  logic [DATA_W-1:0]     s_pwdata,
    output logic [DATA_W-1:0]     s_prdata,
    output logic                  s_pready,
    output logic                  s_pslverr,
    output logic [NCH-1:0]        m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [CH_AW-1:0]      m_paddr,
    output logic [DATA_W-1:0]     m_pwdata,
    input  logic [NCH*DATA_W-1:0] m_prdata,
    input  logic [NCH-1:0]        m_pready,
    input  logic [NCH-1:0]        m_pslverr,
    input  logic [NCH-1:0]        mvu_irq,
    output logic [NCH-1:0]        irq_o,
    output logic                  irq_any_o
);

    localparam int SELW  = $clog2(NCH + 1);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CH_AW-1:0] OFF_PENDING = CH_AW'(4'h0);
    localparam logic [CH_AW-1:0] OFF_MASK    = CH_AW'(4'h4);
    localparam logic [CH_AW-1:0] OFF_RAW     = CH_AW'(4'h8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state_reg;
    logic [SELW-1:0]    sel_reg;
    logic               write_reg;
    logic [CH_AW-1:0]   paddr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NCH-1:0]     m_psel_reg;
    logic               m_penable_reg;
    logic               s_pready_reg;
    logic               s_pslverr_reg;
    logic [DATA_W-1:0]  s_prdata_reg;
    logic [NCH-1:0]     pending_reg;
    logic [NCH-1:0]     mask_reg;
    logic [NCH-1:0]     irq_hist_reg;
    logic [NCH-1:0]     irq_reg;

    // ------------------------------------------------------------------
    // Request decode (combinational, evaluated on the upstream SETUP phase)
    // ------------------------------------------------------------------
    logic               setup_req;
    logic [SELW-1:0]    req_sel;
    logic [CH_AW-1:0]   req_off;
    logic [NCH-1:0]     req_dec;
    logic               req_local;
    logic               req_chan;
    logic               local_err;
    logic [DATA_W-1:0]  local_rdata;
    logic [NCH-1:0]     w1c_next;

    assign setup_req = (state_reg == IDLE) && s_psel && !s_penable;
    assign req_sel   = s_paddr[CH_AW +: SELW];
    assign req_off   = s_paddr[CH_AW-1:0];
    assign req_local = (req_sel == SELW'(NCH));
    assign req_chan  = (req_sel <  SELW'(NCH));

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_req_dec
            assign req_dec[gi] = (req_sel == SELW'(gi));
        end
    endgenerate

    always_comb begin
        local_err   = 1'b0;
        local_rdata = '0;
        case (req_off)
            OFF_PENDING: local_rdata = DATA_W'(pending_reg);
            OFF_MASK:    local_rdata = DATA_W'(mask_reg);
            OFF_RAW:     local_rdata = DATA_W'(mvu_irq);
            default:     local_err   = 1'b1;
        endcase
    end

    // W1C strobe for PENDING, applied on the same edge that completes the
    // local write.
    always_comb begin
        w1c_next = '0;
        if (setup_req && req_local && s_pwrite && (req_off == OFF_PENDING)) begin
            w1c_next = s_pwdata[NCH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Selected-channel response mux. m_psel_reg is one-hot during
    // SETUP/ACCESS, so it doubles as the mux select.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ch_rdata [NCH];
    logic [DATA_W-1:0] sel_rdata;
    logic              sel_ready;
    logic              sel_err;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_rdata
            assign ch_rdata[gi] = m_prdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_psel_reg[i]) begin
                sel_rdata = sel_rdata | ch_rdata[i];
            end
        end
    end

    assign sel_ready = |(m_pready  & m_psel_reg);
    assign sel_err   = |(m_pslverr & m_psel_reg);

    // ------------------------------------------------------------------
    // Transfer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            write_reg     <= 1'b0;
            paddr_reg     <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            m_psel_reg    <= '0;
            m_penable_reg <= 1'b0;
            s_pready_reg  <= 1'b0;
            s_pslverr_reg <= 1'b0;
            s_prdata_reg  <= '0;
            mask_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (setup_req) begin
                        sel_reg   <= req_sel;
                        write_reg <= s_pwrite;
                        paddr_reg <= req_off;
                        wdata_reg <= s_pwdata;
                        if (req_chan) begin
                            m_psel_reg <= req_dec;
                            state_reg  <= SETUP;
                        end else if (req_local) begin
                            // Local register access finishes here; RESP follows.
                            s_pready_reg  <= 1'b1;
                            s_pslverr_reg <= local_err;
                            s_prdata_reg  <= (s_pwrite || local_err) ? '0 : local_rdata;
                            if (s_pwrite && (req_off == OFF_MASK)) begin
                                mask_reg <= s_pwdata[NCH-1:0];
                            end
                            state_reg <= RESP;
                        end else begin
                            // No target behind this index.
                            s_pready_reg  <= 1'b1;
                            s_pslverr_reg <= 1'b1;
                            s_prdata_reg  <= '0;
                            state_reg     <= RESP;
                        end
                    end
                end

                SETUP: begin
                    m_penable_reg <= 1'b1;
                    cnt_reg       <= '0;
                    state_reg     <= ACCESS;
                end

                ACCESS: begin
                    // cnt_reg holds the number of ACCESS cycles already spent
                    // without ready; the TIMEOUT-th one aborts.
                    if (sel_ready || (cnt_reg == CNT_W'(TIMEOUT - 1))) begin
                        m_psel_reg    <= '0;
                        m_penable_reg <= 1'b0;
                        s_pready_reg  <= 1'b1;
                        state_reg     <= RESP;
                        if (sel_ready) begin
                            s_pslverr_reg <= sel_err;
                            s_prdata_reg  <= (write_reg || sel_err) ? '0 : sel_rdata;
                        end else begin
                            s_pslverr_reg <= 1'b1;
                            s_prdata_reg  <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RESP: begin
                    s_pready_reg  <= 1'b0;
                    s_pslverr_reg <= 1'b0;
                    s_prdata_reg  <= '0;
                    state_reg     <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IRQ block: rising-edge capture into PENDING. A new edge in the same
    // cycle as a W1C of that bit keeps the bit set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_hist_reg <= '0;
            pending_reg  <= '0;
            irq_reg      <= '0;
        end else begin
            irq_hist_reg <= mvu_irq;
            pending_reg  <= (pending_reg & ~w1c_next) | (mvu_irq & ~irq_hist_reg);
            irq_reg      <= pending_reg & mask_reg;
        end
    end

    // Upper address / data bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{s_paddr[ADDR_W-1:CH_AW+SELW], s_pwdata[DATA_W-1:NCH]};

    assign s_prdata  = s_prdata_reg;
    assign s_pready  = s_pready_reg;
    assign s_pslverr = s_pslverr_reg;
    assign m_psel    = m_psel_reg;
    assign m_penable = m_penable_reg;
    assign m_pwrite  = write_reg;
    assign m_paddr   = paddr_reg;
    assign m_pwdata  = wdata_reg;
    assign irq_o     = irq_reg;
    assign irq_any_o = |irq_reg;

endmodule

// File: tb/tb_mvu_apb_irq_hub.sv
// ---------------------------------------------------------------------------
// tb_mvu_apb_irq_hub
//
// Directed bench for mvu_apb_irq_hub (NCH=8, so local regs live at 0x8000
// and index 9 at 0x9000). An APB master task drives one transfer and
// reports latency counted from the upstream setup cycle (setup cycle = 1).
// A simple slave process answers the selected channel after slave_waits
// ACCESS cycles, or never when slave_never is set.
// ---------------------------------------------------------------------------
module tb_mvu_apb_irq_hub;

    localparam int NCH    = 8;
    localparam int DATA_W = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_psel, s_penable, s_pwrite;
    logic [31:0]           s_paddr, s_pwdata;
    logic [31:0]           s_prdata;
    logic                  s_pready, s_pslverr;
    logic [NCH-1:0]        m_psel;
    logic                  m_penable, m_pwrite;
    logic [11:0]           m_paddr;
    logic [31:0]           m_pwdata;
    logic [NCH*DATA_W-1:0] m_prdata;
    logic [NCH-1:0]        m_pready;
    logic [NCH-1:0]        m_pslverr;
    logic [NCH-1:0]        mvu_irq;
    logic [NCH-1:0]        irq_o;
    logic                  irq_any_o;

    mvu_apb_irq_hub #(
        .NCH(NCH), .DATA_W(DATA_W), .ADDR_W(32), .CH_AW(12), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .mvu_irq(mvu_irq), .irq_o(irq_o), .irq_any_o(irq_any_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int   slave_waits = 0;
    logic slave_never = 1'b0;
    logic slave_err   = 1'b0;
    int   wcnt        = 0;

    always @(posedge clk) begin
        #1;
        if (m_penable && (|m_psel) && !slave_never) begin
            m_pready = (wcnt == slave_waits) ? m_psel : '0;
            wcnt++;
        end else begin
            m_pready = '0;
            wcnt     = 0;
        end
        m_pslverr = slave_err ? m_pready : '0;
    end

    // ---------------- master task ----------------
    logic [NCH-1:0] psel_or, resp_psel, saw_psel;
    logic [11:0]    saw_paddr;
    logic [31:0]    saw_pwdata;
    logic           saw_pwrite;
    logic [31:0]    rd;
    logic           er;
    int             cyc;

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int cycles);
        psel_or   = '0;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_pwrite  = wr;
        s_paddr   = addr;
        s_pwdata  = wdata;
        cycles    = 1;
        @(posedge clk); #1;
        cycles++;
        psel_or   = psel_or | m_psel;
        s_penable = 1'b1;
        while (!s_pready && cycles < 400) begin
            if (m_penable) begin
                saw_psel   = m_psel;
                saw_paddr  = m_paddr;
                saw_pwdata = m_pwdata;
                saw_pwrite = m_pwrite;
            end
            @(posedge clk); #1;
            cycles++;
            psel_or = psel_or | m_psel;
        end
        check("pready_seen", 32'(s_pready), 32'd1);
        rdata     = s_prdata;
        err       = s_pslverr;
        resp_psel = m_psel;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1;
        s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0; s_pwdata = '0;
        mvu_irq = '0; m_pready = '0; m_pslverr = '0;
        for (int i = 0; i < NCH; i++) m_prdata[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
        m_prdata[5*32 +: 32] = 32'h0000_1234;
        m_prdata[1*32 +: 32] = 32'h0000_5555;
        tick(3);
        check("rst_pready", 32'(s_pready), 0);
        check("rst_psel",   32'(m_psel), 0);
        check("rst_penable",32'(m_penable), 0);
        check("rst_irq",    32'(irq_o), 0);
        check("rst_prdata", s_prdata, 0);
        rst = 1'b0;
        tick(1);

        // 1: write ch3 offset 0x10, zero-wait
        apb_xfer(1'b1, 32'h0000_3010, 32'hDEAD_BEEF, rd, er, cyc);
        $display("T1 write ch3 cycles=%0d err=%0d psel=0x%02h paddr=0x%03h", cyc, er, saw_psel, saw_paddr);
        check("t1_psel",   32'(saw_psel), 32'h08);
        check("t1_paddr",  32'(saw_paddr), 32'h010);
        check("t1_pwdata", saw_pwdata, 32'hDEAD_BEEF);
        check("t1_pwrite", 32'(saw_pwrite), 1);
        check("t1_cycles", 32'(cyc), 4);
        check("t1_err",    32'(er), 0);
        check("t1_prdata", rd, 0);

        // 2: read ch5 with 3 wait states
        slave_waits = 3;
        apb_xfer(1'b0, 32'h0000_5020, 32'h0, rd, er, cyc);
        $display("T2 read ch5 cycles=%0d rdata=0x%08h", cyc, rd);
        check("t2_rdata",  rd, 32'h0000_1234);
        check("t2_cycles", 32'(cyc), 7);
        check("t2_err",    32'(er), 0);
        slave_waits = 0;

        // slave error on ch1 forces data to zero
        slave_err = 1'b1;
        apb_xfer(1'b0, 32'h0000_1000, 32'h0, rd, er, cyc);
        $display("T2b read ch1 slverr err=%0d rdata=0x%08h", er, rd);
        check("t2b_err",   32'(er), 1);
        check("t2b_rdata", rd, 0);
        slave_err = 1'b0;

        // 3: timeout on ch0
        slave_never = 1'b1;
        apb_xfer(1'b0, 32'h0000_0004, 32'h0, rd, er, cyc);
        $display("T3 timeout ch0 cycles=%0d err=%0d", cyc, er);
        check("t3_cycles", 32'(cyc), 258);
        check("t3_err",    32'(er), 1);
        check("t3_rdata",  rd, 0);
        check("t3_psel",   32'(resp_psel), 0);
        slave_never = 1'b0;

        // 4: mask / pending / irq outputs
        apb_xfer(1'b1, 32'h0000_8004, 32'h0000_0005, rd, er, cyc);
        check("t4_mask_wr_cycles", 32'(cyc), 2);
        check("t4_mask_wr_psel",   32'(psel_or), 0);
        mvu_irq = 8'h03; tick(1); mvu_irq = 8'h00; tick(1);
        check("t4_irq_o",   32'(irq_o), 32'h01);
        check("t4_irq_any", 32'(irq_any_o), 1);
        apb_xfer(1'b0, 32'h0000_8000, 32'h0, rd, er, cyc);
        $display("T4 pending=0x%02h irq_o=0x%02h", rd, irq_o);
        check("t4_pending", rd, 32'h03);
        apb_xfer(1'b0, 32'h0000_8004, 32'h0, rd, er, cyc);
        check("t4_mask_rd", rd, 32'h05);
        apb_xfer(1'b1, 32'h0000_8000, 32'h0000_0001, rd, er, cyc);
        check("t4_w1c_irq_o",   32'(irq_o), 0);
        check("t4_w1c_irq_any", 32'(irq_any_o), 0);
        // level held high: captured once, not re-set after clear
        mvu_irq = 8'h08; tick(2);
        apb_xfer(1'b0, 32'h0000_8008, 32'h0, rd, er, cyc);
        check("t4_raw", rd, 32'h08);
        apb_xfer(1'b1, 32'h0000_8000, 32'h0000_0008, rd, er, cyc);
        tick(2);
        apb_xfer(1'b0, 32'h0000_8000, 32'h0, rd, er, cyc);
        $display("T4 level-held pending=0x%02h", rd);
        check("t4_level_pending", rd, 32'h02);
        mvu_irq = 8'h00; tick(1);
        apb_xfer(1'b0, 32'h0000_800C, 32'h0, rd, er, cyc);
        check("t4_badoff_err",   32'(er), 1);
        check("t4_badoff_rdata", rd, 0);

        // 5: set wins over same-cycle W1C
        mvu_irq = 8'h04; tick(1); mvu_irq = 8'h00; tick(1);
        mvu_irq = 8'h04;
        apb_xfer(1'b1, 32'h0000_8000, 32'h0000_0004, rd, er, cyc);
        mvu_irq = 8'h00;
        apb_xfer(1'b0, 32'h0000_8000, 32'h0, rd, er, cyc);
        $display("T5 set-vs-w1c pending=0x%02h", rd);
        check("t5_pending", rd, 32'h06);
        apb_xfer(1'b0, 32'h0000_9000, 32'h0, rd, er, cyc);
        $display("T5 sel=NCH+1 err=%0d psel=0x%02h", er, psel_or);
        check("t5_bad_err",    32'(er), 1);
        check("t5_bad_psel",   32'(psel_or), 0);
        check("t5_bad_rdata",  rd, 0);
        check("t5_bad_cycles", 32'(cyc), 2);

        // 6: reset during ACCESS
        apb_xfer(1'b1, 32'h0000_8004, 32'h0000_00FF, rd, er, cyc);
        slave_never = 1'b1;
        s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 32'h0000_0000;
        tick(1);
        s_penable = 1;
        tick(3);
        check("t6_pre_psel", 32'(m_psel), 32'h01);
        rst = 1'b1;
        tick(1);
        check("t6_rst_psel",   32'(m_psel), 0);
        check("t6_rst_pready", 32'(s_pready), 0);
        rst = 1'b0; s_psel = 0; s_penable = 0; slave_never = 1'b0;
        tick(1);
        check("t6_no_pready", 32'(s_pready), 0);
        apb_xfer(1'b0, 32'h0000_8000, 32'h0, rd, er, cyc);
        check("t6_pending", rd, 0);
        apb_xfer(1'b0, 32'h0000_8004, 32'h0, rd, er, cyc);
        check("t6_mask", rd, 0);
        apb_xfer(1'b1, 32'h0000_3010, 32'h1111_2222, rd, er, cyc);
        $display("T6 post-reset write ch3 cycles=%0d err=%0d", cyc, er);
        check("t6_cycles", 32'(cyc), 4);
        check("t6_err",    32'(er), 0);
        check("t6_psel",   32'(saw_psel), 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
